// File: rtl/pc_pkg.sv
// pc_pkg: shared constants and next-PC source encoding for the fetch PC logic
package pc_pkg;
    localparam int PC_WIDTH = 32;
    localparam int INSTR_BYTES = 4;
    typedef enum logic [2:0] {SRC_SEQ, SRC_BRANCH, SRC_JUMP, SRC_CALL, SRC_RET} pc_src_e;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack; a push when full overwrites the oldest entry
module ras_stack #(
    parameter int WIDTH = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic do_pop;
    assign empty = cnt_q == '0;
    assign full = cnt_q == CW'(RAS_DEPTH);
    assign top = mem_q[ptr_q - PW'(1)];
    always_comb begin
        do_pop = pop && !push && !empty;
        ptr_d = push ? ptr_q + PW'(1) : do_pop ? ptr_q - PW'(1) : ptr_q;
        cnt_d = (push && !full) ? cnt_q + CW'(1) : do_pop ? cnt_q - CW'(1) : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[ptr_q] <= push_data;
    end
endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: registered PC with branch/jump/call/return selection and a return-address stack
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int IMM_SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] simm,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_underflow
);
    pc_src_e src;
    logic [WIDTH-1:0] pc_q, pc_d, ras_top;
    logic uf_q, uf_d, push, pop;
    assign pc = pc_q;
    assign pc_plus4 = pc_q + WIDTH'(INSTR_BYTES);
    assign ras_underflow = uf_q;
    always_comb begin
        src = ret ? SRC_RET : call ? SRC_CALL : jump ? SRC_JUMP : branch_taken ? SRC_BRANCH : SRC_SEQ;
        push = !stall && src == SRC_CALL;
        pop = !stall && src == SRC_RET && !ras_empty;
        uf_d = !stall && src == SRC_RET && ras_empty;
        pc_d = stall ? pc_q :
               src == SRC_RET ? (ras_empty ? pc_plus4 : ras_top) :
               (src == SRC_CALL || src == SRC_JUMP) ? jump_target :
               src == SRC_BRANCH ? pc_plus4 + (simm << IMM_SHIFT) : pc_plus4;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
            uf_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            uf_q <= uf_d;
        end
    end
    ras_stack #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .push_data(pc_plus4),
        .top(ras_top),
        .empty(ras_empty),
        .full(ras_full)
    );
endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed and random checks of pc_next_unit against a queue-based model
module tb_pc_next_unit;
    localparam int W = 32;
    localparam int D = 4;
    logic clk = 0, reset = 0, stall = 0, branch_taken = 0, jump = 0, call = 0, ret = 0;
    logic [W-1:0] simm = '0, jump_target = '0;
    logic [W-1:0] pc, pc_plus4, pc2, pc2_plus4;
    logic ras_empty, ras_full, ras_underflow, ras_empty2, ras_full2, ras_underflow2;
    int total = 0, bad = 0;
    logic [W-1:0] m_pc;
    logic [W-1:0] m_stack[$];
    logic m_uf;

    always #5 clk = ~clk;

    pc_next_unit #(.WIDTH(W), .RAS_DEPTH(D), .RESET_PC(32'h0), .IMM_SHIFT(2)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken), .simm(simm),
        .jump(jump), .jump_target(jump_target), .call(call), .ret(ret), .pc(pc),
        .pc_plus4(pc_plus4), .ras_empty(ras_empty), .ras_full(ras_full), .ras_underflow(ras_underflow));

    pc_next_unit #(.WIDTH(W), .RAS_DEPTH(D), .RESET_PC(32'h1000), .IMM_SHIFT(2)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken), .simm(simm),
        .jump(jump), .jump_target(jump_target), .call(call), .ret(ret), .pc(pc2),
        .pc_plus4(pc2_plus4), .ras_empty(ras_empty2), .ras_full(ras_full2), .ras_underflow(ras_underflow2));

    task automatic drive(input logic rs, input logic st, input logic br, input logic [W-1:0] si,
                         input logic jp, input logic [W-1:0] jt, input logic cl, input logic rt);
        logic [W-1:0] np;
        reset = rs; stall = st; branch_taken = br; simm = si; jump = jp; jump_target = jt; call = cl; ret = rt;
        np = m_pc + 4;
        if (rs) begin
            m_pc = 32'h0; m_stack.delete(); m_uf = 0;
        end else if (st) begin
            m_uf = 0;
        end else if (rt) begin
            m_uf = (m_stack.size() == 0);
            m_pc = m_uf ? np : m_stack.pop_back();
        end else begin
            m_uf = 0;
            if (cl) begin
                m_stack.push_back(np);
                if (m_stack.size() > D) void'(m_stack.pop_front());
                m_pc = jt;
            end else if (jp) m_pc = jt;
            else if (br) m_pc = np + (si << 2);
            else m_pc = np;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(); drive(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic go(input logic [W-1:0] a); drive(0, 0, 0, 0, 1, a, 0, 0); endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL reset_pc_plus4 got=%h exp=%h", pc_plus4, 32'h4); end
        total++; if ({ras_empty, ras_full, ras_underflow} !== 3'b100) begin bad++; $display("FAIL reset_flags got=%b exp=100", {ras_empty, ras_full, ras_underflow}); end
        for (int i = 1; i <= 3; i++) begin
            idle();
            total++; if (pc !== 32'(4 * i)) begin bad++; $display("FAIL seq_step%0d got=%h exp=%h", i, pc, 32'(4 * i)); end
        end
    endtask

    task automatic test_branch();
        go(32'h100);
        drive(0, 0, 1, 32'hFFFF_FFFE, 0, 0, 0, 0);
        total++; if (pc !== 32'hFC) begin bad++; $display("FAIL branch_back got=%h exp=%h", pc, 32'hFC); end
        go(32'h100);
        drive(0, 0, 1, 32'h3, 0, 0, 0, 0);
        total++; if (pc !== 32'h110) begin bad++; $display("FAIL branch_fwd got=%h exp=%h", pc, 32'h110); end
        go(32'h123);
        total++; if (pc !== 32'h123) begin bad++; $display("FAIL jump_unmasked got=%h exp=%h", pc, 32'h123); end
    endtask

    task automatic test_call_ret();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        go(32'h40);
        drive(0, 0, 0, 0, 0, 32'h200, 1, 0);
        total++; if (pc !== 32'h200 || ras_empty !== 1'b0) begin bad++; $display("FAIL call1 got=%h/%b exp=200/0", pc, ras_empty); end
        drive(0, 0, 0, 0, 0, 32'h300, 1, 0);
        total++; if (pc !== 32'h300) begin bad++; $display("FAIL call2 got=%h exp=%h", pc, 32'h300); end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        total++; if (pc !== 32'h204) begin bad++; $display("FAIL ret1 got=%h exp=%h", pc, 32'h204); end
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        total++; if (pc !== 32'h44 || ras_empty !== 1'b1) begin bad++; $display("FAIL ret2 got=%h/%b exp=44/1", pc, ras_empty); end
    endtask

    task automatic test_overflow();
        logic [W-1:0] exp_t[5];
        exp_t[0] = 32'h54; exp_t[1] = 32'h44; exp_t[2] = 32'h34; exp_t[3] = 32'h24; exp_t[4] = 32'h28;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            go(32'(16 * i));
            drive(0, 0, 0, 0, 0, 32'h800, 1, 0);
            total++; if (ras_full !== (i >= 4)) begin bad++; $display("FAIL full_after_call%0d got=%b exp=%b", i, ras_full, i >= 4); end
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1);
            total++; if (pc !== exp_t[i]) begin bad++; $display("FAIL wrap_ret%0d got=%h exp=%h", i, pc, exp_t[i]); end
            total++; if (ras_underflow !== (i == 4)) begin bad++; $display("FAIL wrap_uf%0d got=%b exp=%b", i, ras_underflow, i == 4); end
        end
        idle();
        total++; if (ras_underflow !== 1'b0 || ras_empty !== 1'b1) begin bad++; $display("FAIL uf_pulse_end got=%b/%b exp=0/1", ras_underflow, ras_empty); end
    endtask

    task automatic test_stall_priority();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        go(32'h60);
        drive(0, 0, 0, 0, 0, 32'h500, 1, 0);
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 0, 0, 32'h900, 1, 0);
            total++; if (pc !== 32'h500) begin bad++; $display("FAIL stall_pc%0d got=%h exp=%h", i, pc, 32'h500); end
        end
        drive(0, 1, 0, 0, 0, 0, 0, 1);
        total++; if (pc !== 32'h500 || ras_underflow !== 1'b0) begin bad++; $display("FAIL stall_ret got=%h/%b exp=500/0", pc, ras_underflow); end
        drive(0, 0, 0, 0, 1, 32'hA00, 1, 1);
        total++; if (pc !== 32'h64 || ras_empty !== 1'b1) begin bad++; $display("FAIL prio_ret got=%h/%b exp=64/1", pc, ras_empty); end
        drive(0, 0, 0, 0, 1, 32'hA00, 1, 1);
        total++; if (pc !== 32'h68 || ras_underflow !== 1'b1 || ras_empty !== 1'b1) begin bad++; $display("FAIL prio_uf got=%h/%b/%b exp=68/1/1", pc, ras_underflow, ras_empty); end
    endtask

    task automatic test_mid_reset();
        go(32'h700);
        drive(0, 0, 0, 0, 0, 32'h880, 1, 0);
        drive(1, 1, 0, 0, 0, 32'h990, 1, 0);
        total++; if (pc2 !== 32'h1000 || pc2_plus4 !== 32'h1004) begin bad++; $display("FAIL midreset_pc got=%h/%h exp=1000/1004", pc2, pc2_plus4); end
        total++; if (ras_empty2 !== 1'b1 || ras_empty !== 1'b1 || pc !== 32'h0) begin bad++; $display("FAIL midreset_empty got=%b/%b/%h exp=1/1/0", ras_empty2, ras_empty, pc); end
    endtask

    task automatic test_random();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 64) == 0, ($urandom % 8) == 0, $urandom % 2, $urandom, ($urandom % 4) == 0,
                  $urandom, ($urandom % 3) == 0, ($urandom % 3) == 0);
            total++; if (pc !== m_pc || pc_plus4 !== m_pc + 4) begin bad++; $display("FAIL rnd_pc%0d got=%h/%h exp=%h/%h", i, pc, pc_plus4, m_pc, m_pc + 4); end
            total++; if (ras_empty !== (m_stack.size() == 0) || ras_full !== (m_stack.size() == D) || ras_underflow !== m_uf) begin
                bad++; $display("FAIL rnd_flags%0d got=%b%b%b exp=%b%b%b", i, ras_empty, ras_full, ras_underflow, m_stack.size() == 0, m_stack.size() == D, m_uf);
            end
        end
    endtask

    initial begin
        m_pc = '0; m_uf = 0;
        test_reset();
        test_branch();
        test_call_ret();
        test_overflow();
        test_stall_priority();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_next_unit.md
PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the PC/immediate/target width in bits.
REQ-002 The block SHALL have parameter RAS_DEPTH, default 4, giving the return-address-stack entry count (power of two, at least 2).
REQ-003 The block SHALL have parameter RESET_PC, default 0, giving the PC value loaded on reset.
REQ-004 The block SHALL have parameter IMM_SHIFT, default 2, giving the left shift applied to simm before the branch add.
REQ-005 Port list SHALL be (name, direction, width, meaning):
  clk  in  1  sole clock, rising edge
  reset  in  1  synchronous, active-high reset
  stall  in  1  hold PC and stack this cycle
  branch_taken  in  1  select branch target
  simm  in  WIDTH  sign-extended branch offset (two's complement)
  jump  in  1  select jump_target
  jump_target  in  WIDTH  absolute jump/call target
  call  in  1  push return address and go to jump_target
  ret  in  1  pop return address and go to it
  pc  out  WIDTH  current PC, registered
  pc_plus4  out  WIDTH  pc + 4, combinational from pc
  ras_empty  out  1  stack holds 0 entries
  ras_full  out  1  stack holds RAS_DEPTH entries
  ras_underflow  out  1  registered one-cycle pulse: ret issued on empty stack

Function
REQ-006 pc SHALL update on every rising clk edge unless reset or stall is high.
REQ-007 Next-PC priority SHALL be: ret > call > jump > branch_taken > sequential.
REQ-008 Sequential next PC SHALL be pc + 4, modulo 2^WIDTH.
REQ-009 Branch target SHALL be pc + 4 + (simm << IMM_SHIFT), truncated to WIDTH bits, with no overflow flag.
REQ-010 jump SHALL load jump_target unchanged; low bits SHALL NOT be masked.
REQ-011 call SHALL load jump_target into pc and push pc + 4 in the same edge.
REQ-012 ret on a non-empty stack SHALL load the top entry into pc and pop it in the same edge.
REQ-013 ret on an empty stack SHALL load pc + 4, leave the stack empty, and set ras_underflow high for exactly the following cycle.
REQ-014 call on a full stack SHALL overwrite the oldest entry (circular wrap); count SHALL stay RAS_DEPTH and ras_full SHALL stay high.
REQ-015 call and ret asserted together SHALL act as ret only; call SHALL be ignored and there SHALL be no push.
REQ-016 While stall is high: pc, stack contents, and count SHALL hold; ras_underflow SHALL be 0; all control inputs SHALL be ignored.
REQ-017 ras_empty and ras_full SHALL be combinational decodes of the registered entry count (0..RAS_DEPTH).
REQ-018 The stack pointer SHALL wrap modulo RAS_DEPTH on both push and pop.

Reset
REQ-019 On a reset edge: pc = RESET_PC, count = 0, ras_underflow = 0, ras_empty = 1, ras_full = 0.
REQ-020 Stack entry storage SHALL NOT need clearing on reset; entries SHALL be unreachable while count = 0.
REQ-021 reset SHALL override stall and every control input, including mid-call/ret.
REQ-022 pc_plus4 SHALL equal RESET_PC + 4 in the cycle after reset.

Structure
REQ-023 A shared package pc_pkg SHALL hold the following, and pc_next_unit SHALL import it:
  - INSTR_BYTES = 4
  - next-PC source enum: SRC_SEQ, SRC_BRANCH, SRC_JUMP, SRC_CALL, SRC_RET
  - default WIDTH
REQ-024 The return-address stack SHALL be one sub-module, ras_stack, with:
  - parameters WIDTH and RAS_DEPTH
  - ports clk, reset, push, pop, push_data, top, empty, full
  - circular storage, pointer, and count

Verification
REQ-025 Reset and sequential step: reset for 1 cycle, then 3 free cycles -> pc = 0x0, 0x4, 0x8, 0xC.
REQ-026 Branch: pc = 0x100, branch_taken = 1, simm = 0xFFFFFFFE -> next pc = 0xFC; simm = 0x3 -> next pc = 0x110.
REQ-027 Call/return nesting: pc = 0x40 call to 0x200, then pc = 0x200 call to 0x300, then ret twice -> pc = 0x300, 0x204, 0x44; ras_empty = 1.
REQ-028 Overflow wrap (RAS_DEPTH = 4): 5 calls from 0x10, 0x20, 0x30, 0x40, 0x50, then 5 rets -> targets 0x54, 0x44, 0x34, 0x24, then underflow; fifth ret gives pc = 0x28 (0x24 + 4) and a 1-cycle ras_underflow pulse.
REQ-029 Stall and priority:
  - stall with call high for 2 cycles -> pc and count unchanged.
  - call + ret + jump together -> ret only (or underflow if stack empty).
REQ-030 Mid-operation reset: reset asserted in the same cycle as call with RESET_PC = 0x1000 -> pc = 0x1000, ras_empty = 1, no push.
